// File: rtl/key_event_fifo_if.sv
// CPU/scanner-side bus of the key event FIFO: scanner strobe plus the
// chip-select/address/read/write register interface, read data and irq.
interface key_event_fifo_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  key_row;
  logic [3:0]  key_column;
  logic        keyfifoCtrl;
  logic        read_enable;
  logic        write_enable;
  logic [3:0]  address;
  logic [15:0] write_data;
  logic [15:0] read_data_output;
  logic        irq;

  // Handshake: key_valid is a one-cycle strobe with no back-pressure. A
  // register access is taken on any edge where keyfifoCtrl and
  // read_enable/write_enable are high; read data appears the next cycle.
  modport master (
    output key_valid, key_code, key_row, key_column,
    output keyfifoCtrl, read_enable, write_enable, address, write_data,
    input  read_data_output, irq
  );

  modport slave (
    input  key_valid, key_code, key_row, key_column,
    input  keyfifoCtrl, read_enable, write_enable, address, write_data,
    output read_data_output, irq
  );
endinterface

// File: rtl/key_event_fifo.sv
// Circular FIFO of keypad events, popped by the CPU through a DATA register,
// with STATUS/CTRL registers and a level interrupt while events are pending.
module key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic            clock,
  input  logic            reset,
  key_event_fifo_if.slave bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [11:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             irq_en_q, irq_en_d;
  logic [15:0]      rdata_q, rdata_d;

  logic rd_sel, wr_sel, pop_do, push_do, flush, clr_ovf, ovf_set, full, nonempty;
  logic unused_wdata;

  assign unused_wdata = ^bus.write_data[15:3];
  assign full         = (count_q == FULL_CNT);
  assign nonempty     = (count_q != '0);

  // A read takes priority, so a simultaneous write strobe never reaches CTRL.
  assign rd_sel  = bus.keyfifoCtrl && bus.read_enable;
  assign wr_sel  = bus.keyfifoCtrl && bus.write_enable && !bus.read_enable
                   && (bus.address == 4'h4);
  assign pop_do  = rd_sel && (bus.address == 4'h0) && nonempty;
  assign flush   = wr_sel && bus.write_data[0];
  assign clr_ovf = wr_sel && bus.write_data[1];
  assign push_do = bus.key_valid && !flush && (!full || pop_do);
  assign ovf_set = bus.key_valid && !flush && full && !pop_do;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;
    rdata_d    = 16'h0000;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_do) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_do)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_do, pop_do})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // A set on the same edge as a clear leaves overflow asserted.
    if (ovf_set)      overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;

    if (wr_sel) irq_en_d = bus.write_data[2];

    if (rd_sel) begin
      case (bus.address)
        4'h0:    rdata_d = pop_do ? {4'h0, mem_q[rd_ptr_q]} : 16'h0000;
        4'h2:    rdata_d = {4'h0, {(7-PTR_W){1'b0}}, count_q, 1'b0,
                            overflow_q, full, nonempty};
        4'h4:    rdata_d = {13'b0, irq_en_q, 2'b00};
        default: rdata_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      rdata_q    <= 16'h0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage needs no reset; only the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (push_do) mem_q[wr_ptr_q] <= {bus.key_row, bus.key_column, bus.key_code};
  end

  assign bus.read_data_output = rdata_q;
  assign bus.irq              = irq_en_q && nonempty;

endmodule

// File: tb/tb_key_event_fifo.sv
// Bench for key_event_fifo: vector table plus hand-written corner sequences,
// with a queue-based reference model feeding an expected-read-data queue.
module tb_key_event_fifo;

  logic clock;
  logic reset;
  key_event_fifo_if bus ();

  key_event_fifo #(.DEPTH(8), .PTR_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        kv;
    logic [3:0]  code, row, col;
    logic        sel, re, we;
    logic [3:0]  addr;
    logic [15:0] wd;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] exp_q[$];
  logic [11:0] model_q[$];
  logic        ovf_m, irq_en_m;
  int          n_vec, n_err;

  function automatic vec_t mk(logic kv, logic [3:0] code, logic [3:0] row,
                              logic [3:0] col, logic sel, logic re, logic we,
                              logic [3:0] addr, logic [15:0] wd, logic chk,
                              logic [15:0] exp);
    vec_t v;
    v.kv = kv; v.code = code; v.row = row; v.col = col;
    v.sel = sel; v.re = re; v.we = we; v.addr = addr; v.wd = wd;
    v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.key_valid = 0; bus.key_code = 0; bus.key_row = 0; bus.key_column = 0;
    bus.keyfifoCtrl = 0; bus.read_enable = 0; bus.write_enable = 0;
    bus.address = 0; bus.write_data = 0;
  endtask

  function automatic logic [15:0] model_status();
    logic [7:0] cnt;
    cnt = 8'(model_q.size());
    return {4'h0, cnt, 1'b0, ovf_m, model_q.size() == 8, model_q.size() != 0};
  endfunction

  // driver: one clock of stimulus, model update, then scoreboard compare
  task automatic drive(input vec_t v);
    logic        rd, wr, pop, push, flush, full;
    logic [15:0] e;
    bus.key_valid = v.kv; bus.key_code = v.code; bus.key_row = v.row;
    bus.key_column = v.col; bus.keyfifoCtrl = v.sel; bus.read_enable = v.re;
    bus.write_enable = v.we; bus.address = v.addr; bus.write_data = v.wd;

    rd    = v.sel && v.re;
    wr    = v.sel && v.we && !v.re && v.addr == 4'h4;
    full  = model_q.size() == 8;
    pop   = rd && v.addr == 4'h0 && model_q.size() != 0;
    flush = wr && v.wd[0];
    push  = v.kv && !flush && (!full || pop);
    e = 16'h0000;
    if (rd) begin
      case (v.addr)
        4'h0: e = pop ? {4'h0, model_q[0]} : 16'h0000;
        4'h2: e = model_status();
        4'h4: e = {13'b0, irq_en_m, 2'b00};
        default: e = 16'h0000;
      endcase
    end
    exp_q.push_back(e);
    if (flush) model_q.delete();
    else begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back({v.row, v.col, v.code});
    end
    if (v.kv && !flush && full && !pop) ovf_m = 1'b1;
    else if (wr && v.wd[1])             ovf_m = 1'b0;
    if (wr) irq_en_m = v.wd[2];

    @(posedge clock);
    #1;
    idle_inputs();
    check16("read_data", bus.read_data_output, exp_q.pop_front());
    check16("irq", {15'b0, bus.irq}, {15'b0, irq_en_m && model_q.size() != 0});
    if (v.chk) check16("table_const", bus.read_data_output, v.exp);
  endtask

  task automatic push_key(input logic [3:0] code);
    drive(mk(1, code, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic rd_reg(input logic [3:0] addr, input logic chk, input logic [15:0] exp);
    drive(mk(0, 0, 0, 0, 1, 1, 0, addr, 0, chk, exp));
  endtask

  task automatic wr_ctrl(input logic [15:0] wd, input logic kv);
    drive(mk(kv, 4'hA, 4'h1, 4'h2, 1, 0, 1, 4'h4, wd, 0, 0));
  endtask

  task automatic model_reset();
    model_q.delete(); exp_q.delete(); ovf_m = 0; irq_en_m = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check16("reset_rdata", bus.read_data_output, 16'h0000);
    check16("reset_irq", {15'b0, bus.irq}, 16'h0000);
    reset = 1'b0;

    // single event round trip and register decode
    tbl.push_back(mk(1, 4'h5, 4'hB, 4'hB, 0, 0, 0, 4'h0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'h0, 16'h0000, 1, 16'h0BB5));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'h2, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'h0, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'h4, 16'h0004, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'h4, 16'h0000, 1, 16'h0004));
    tbl.push_back(mk(1, 4'h3, 4'h7, 4'hE, 0, 0, 0, 4'h0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'h2, 16'h0000, 1, 16'h0011));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'h6, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4'h0, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'h0, 16'h0000, 1, 16'h07E3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'h4, 16'h0000, 0, 16'h0000));
    // read and write together: read served, flush ignored
    tbl.push_back(mk(1, 4'h8, 4'h2, 4'h4, 0, 0, 0, 4'h0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 4'h4, 16'h0007, 1, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'h0, 16'h0000, 1, 16'h0248));
    foreach (tbl[i]) drive(tbl[i]);

    // overflow: 9 pushes, status, drain in order, read past empty
    for (int i = 1; i <= 9; i++) push_key(4'(i));
    rd_reg(4'h2, 1, 16'h0087);
    for (int i = 0; i < 8; i++) rd_reg(4'h0, 0, 0);
    rd_reg(4'h0, 1, 16'h0000);
    wr_ctrl(16'h0002, 0);
    rd_reg(4'h2, 1, 16'h0000);

    // full with simultaneous push and pop: no overflow, new entry read last
    for (int i = 0; i < 8; i++) push_key(4'(i + 2));
    drive(mk(1, 4'hF, 4'hC, 4'h3, 1, 1, 0, 4'h0, 0, 0, 0));
    rd_reg(4'h2, 1, 16'h0083);
    for (int i = 0; i < 7; i++) rd_reg(4'h0, 0, 0);
    rd_reg(4'h0, 1, 16'h0C3F);
    rd_reg(4'h2, 1, 16'h0000);

    // empty with simultaneous push and pop: pop returns 0, no bypass
    drive(mk(1, 4'h6, 4'h1, 4'h1, 1, 1, 0, 4'h0, 0, 1, 16'h0000));
    rd_reg(4'h2, 1, 16'h0011);
    rd_reg(4'h0, 1, 16'h0116);

    // interrupt enable, pop clears irq, flush with entries buffered
    wr_ctrl(16'h0004, 0);
    push_key(4'h4);
    rd_reg(4'h0, 0, 0);
    push_key(4'h1); push_key(4'h2); push_key(4'h3);
    wr_ctrl(16'h0005, 0);
    rd_reg(4'h2, 1, 16'h0000);

    // asynchronous reset with 4 entries buffered and irq high
    for (int i = 0; i < 4; i++) push_key(4'(i + 10));
    rd_reg(4'h2, 1, 16'h0041);
    #2 reset = 1'b1;
    #1;
    check16("async_rst_rdata", bus.read_data_output, 16'h0000);
    check16("async_rst_irq", {15'b0, bus.irq}, 16'h0000);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    rd_reg(4'h0, 1, 16'h0000);
    rd_reg(4'h2, 1, 16'h0000);
    rd_reg(4'h4, 1, 16'h0000);

    // flush on the same edge as a push
    push_key(4'h7); push_key(4'h8);
    wr_ctrl(16'h0001, 1);
    rd_reg(4'h2, 1, 16'h0000);

    // overflow clear loses to a simultaneous overflowing push, then clears
    for (int i = 0; i < 9; i++) push_key(4'($urandom_range(0, 15)));
    wr_ctrl(16'h0002, 1);
    rd_reg(4'h2, 1, 16'h0087);
    wr_ctrl(16'h0002, 0);
    rd_reg(4'h2, 1, 16'h0083);
    for (int i = 0; i < 8; i++) rd_reg(4'h0, 0, 0);
    rd_reg(4'h2, 1, 16'h0000);

    // random mix against the model
    for (int i = 0; i < 200; i++) begin
      vec_t v;
      v = mk($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 7) == 0, 4'(2 * $urandom_range(0, 3)),
             16'($urandom_range(0, 7)), 0, 0);
      drive(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
